// File: rtl/pprm_sbox_pipe.sv
// pprm_sbox_pipe: pipelined multi-lane AES S-box / inverse S-box / raw GF(2^8) inverse.
// Define PPRM_SBOX_OPISO_EN for operand isolation (gated loads, zero output when idle).
module pprm_sbox_pipe #(
  parameter int LANES = 4,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_mode,
  output logic [8*LANES-1:0]   out_data,
  output logic                 busy
);
  localparam int W = 8*LANES;
  localparam int WI = 16*LANES;
`ifdef PPRM_SBOX_OPISO_EN
  localparam bit ISO = 1'b1;
`else
  localparam bit ISO = 1'b0;
`endif
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = x[7] ? {x[6:0], 1'b0} ^ 8'h1b : {x[6:0], 1'b0};
    end
    return p;
  endfunction
  function automatic logic [7:0] sq(input logic [7:0] a);
    return gmul(a, a);
  endfunction
  // Inversion as x^254 split in three: {x^2,x^3} -> {x^14,x^15} -> x^240*x^14
  function automatic logic [WI-1:0] f1(input logic [W-1:0] x, input logic [1:0] m);
    logic [WI-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      b = x[8*i+:8];
      b = (m == 2'b01) ? {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05 : b;
      r[16*i+:8] = gmul(sq(b), b);
      r[16*i+8+:8] = sq(b);
    end
    return r;
  endfunction
  function automatic logic [WI-1:0] f2(input logic [WI-1:0] q);
    logic [WI-1:0] r;
    logic [7:0] x12;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x12 = sq(sq(q[16*i+:8]));
      r[16*i+:8] = gmul(x12, q[16*i+:8]);
      r[16*i+8+:8] = gmul(x12, q[16*i+8+:8]);
    end
    return r;
  endfunction
  function automatic logic [W-1:0] f3(input logic [WI-1:0] q, input logic [1:0] m);
    logic [W-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      b = gmul(sq(sq(sq(sq(q[16*i+:8])))), q[16*i+8+:8]);
      r[8*i+:8] = (m == 2'b00) ?
        b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63 : b;
    end
    return r;
  endfunction
  logic          va, vb, vo, adv_a, adv_b, adv_o;
  logic [1:0]    ma, mb, mo;
  logic [WI-1:0] s1, s2, qa, qb;
  logic [W-1:0]  s3, qo;
  assign s1 = f1(in_data & {W{in_valid | ~ISO}}, in_mode);
  assign s2 = f2(qa & {WI{va | ~ISO}});
  assign s3 = f3(qb & {WI{vb | ~ISO}}, mb);
  generate
    if (PIPE_DEPTH >= 2) begin : g_a
      always_ff @(posedge clk)
        if (rst) begin
          va <= 1'b0;
          ma <= '0;
          qa <= '0;
        end else if (adv_a) begin
          va <= in_valid;
          if (in_valid | ~ISO) begin
            ma <= in_mode;
            qa <= s1;
          end
        end
      assign adv_a = ~va | adv_b;
    end else begin : g_na
      assign va = in_valid;
      assign ma = in_mode;
      assign qa = s1;
      assign adv_a = adv_b;
    end
    if (PIPE_DEPTH == 3) begin : g_b
      always_ff @(posedge clk)
        if (rst) begin
          vb <= 1'b0;
          mb <= '0;
          qb <= '0;
        end else if (adv_b) begin
          vb <= va;
          if (va | ~ISO) begin
            mb <= ma;
            qb <= s2;
          end
        end
      assign adv_b = ~vb | adv_o;
    end else begin : g_nb
      assign vb = va;
      assign mb = ma;
      assign qb = s2;
      assign adv_b = adv_o;
    end
  endgenerate
  always_ff @(posedge clk)
    if (rst) begin
      vo <= 1'b0;
      mo <= '0;
      qo <= '0;
    end else if (adv_o) begin
      vo <= vb;
      if (vb | ~ISO) begin
        mo <= mb;
        qo <= s3;
      end
    end
  assign adv_o = ~vo | out_ready;
  assign in_ready = adv_a & ~rst;
  assign out_valid = vo;
  assign out_mode = mo;
  assign out_data = qo & {W{vo | ~ISO}};
  assign busy = (PIPE_DEPTH >= 2 && va) | (PIPE_DEPTH == 3 && vb) | vo;
endmodule
